// File: rtl/flash_cmd_scheduler.sv
`timescale 1ns/1ps
// flash_cmd_scheduler: two-way round-robin arbiter and sequencer in front of
// flash_interface. Write-class opcodes get an automatic Write Enable before
// the command. With FLASH_SCHED_POLL_EN defined, Read Status is then polled
// until WIP clears or POLL_LIMIT polls have been made (error). Without the
// macro the poll states and counter are not built and error is tied low.
//
// Handshake: a requester holds req_valid until its grant bit rises; request
// fields are captured only in that acceptance cycle. grant stays high through
// the done cycle. Towards flash_interface, fi_start is a one-cycle launch that
// is only issued while fi_busy is low, and fi_* fields stay stable until the
// matching fi_done pulse.
module flash_cmd_scheduler #(
  parameter int POLL_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req0_instr,
  input  logic [7:0]  req1_instr,
  input  logic [23:0] req0_addr,
  input  logic [23:0] req1_addr,
  input  logic [15:0] req0_len,
  input  logic [15:0] req1_len,
  output logic [1:0]  grant,
  output logic        done,
  output logic        error,
  output logic [7:0]  fi_instruction,
  output logic [23:0] fi_addr,
  output logic [15:0] fi_len,
  output logic        fi_start,
  input  logic        fi_busy,
  input  logic        fi_done,
  input  logic [7:0]  fi_status,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WREN_ISSUE = 3'd1,
    WREN_WAIT  = 3'd2,
    CMD_ISSUE  = 3'd3,
    CMD_WAIT   = 3'd4,
    POLL_ISSUE = 3'd5,
    POLL_WAIT  = 3'd6,
    FINISH     = 3'd7
  } state_e;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDSR = 8'h05;

  state_e      state_q;
  logic        last_q;     // requester served most recently
  logic [1:0]  grant_q;
  logic        done_q;
  logic        fi_start_q;
  logic [7:0]  fi_instr_q;
  logic [23:0] fi_addr_q;
  logic [15:0] fi_len_q;
  logic [7:0]  instr_q;
  logic [23:0] addr_q;
  logic [15:0] len_q;
  logic        wr_q;

  logic        pick;
  logic [7:0]  sel_instr;
  logic [23:0] sel_addr;
  logic [15:0] sel_len;
  logic        sel_wr;

`ifdef FLASH_SCHED_POLL_EN
  localparam logic [15:0] LIMIT = 16'(POLL_LIMIT);
  logic        error_q;
  logic [15:0] poll_cnt_q;
  logic [15:0] poll_next;
  assign poll_next = poll_cnt_q + 16'd1;
  assign error = error_q;
  logic unused_status;
  assign unused_status = ^fi_status[7:1];
`else
  assign error = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{fi_status, POLL_LIMIT[0]};
`endif

  function automatic logic is_write(input logic [7:0] op);
    return (op == 8'h02) || (op == 8'h20) || (op == 8'hD8) ||
           (op == 8'hC7) || (op == 8'h01);
  endfunction

  // Round-robin pick: on a tie favour the requester not served last.
  always_comb begin
    pick = 1'b0;
    if (req_valid == 2'b10) pick = 1'b1;
    else if (req_valid == 2'b11) pick = ~last_q;
    sel_instr = pick ? req1_instr : req0_instr;
    sel_addr  = pick ? req1_addr  : req0_addr;
    sel_len   = pick ? req1_len   : req0_len;
    sel_wr    = is_write(sel_instr);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      grant_q    <= 2'b00;
      done_q     <= 1'b0;
      fi_start_q <= 1'b0;
      fi_instr_q <= 8'h00;
      fi_addr_q  <= 24'h0;
      fi_len_q   <= 16'h0;
      instr_q    <= 8'h00;
      addr_q     <= 24'h0;
      len_q      <= 16'h0;
      wr_q       <= 1'b0;
`ifdef FLASH_SCHED_POLL_EN
      error_q    <= 1'b0;
      poll_cnt_q <= 16'h0;
`endif
    end else begin
      fi_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q <= pick ? 2'b10 : 2'b01;
            instr_q <= sel_instr;
            addr_q  <= sel_addr;
            len_q   <= sel_len;
            wr_q    <= sel_wr;
            state_q <= sel_wr ? WREN_ISSUE : CMD_ISSUE;
          end
        end
        WREN_ISSUE: begin
          if (!fi_busy) begin
            fi_start_q <= 1'b1;
            fi_instr_q <= OP_WREN;
            fi_addr_q  <= 24'h0;
            fi_len_q   <= 16'h0;
            state_q    <= WREN_WAIT;
          end
        end
        WREN_WAIT: begin
          if (fi_done) state_q <= CMD_ISSUE;
        end
        CMD_ISSUE: begin
          if (!fi_busy) begin
            fi_start_q <= 1'b1;
            fi_instr_q <= instr_q;
            fi_addr_q  <= addr_q;
            fi_len_q   <= len_q;
            state_q    <= CMD_WAIT;
          end
        end
        CMD_WAIT: begin
          if (fi_done) begin
`ifdef FLASH_SCHED_POLL_EN
            if (wr_q) begin
              state_q <= POLL_ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
`else
            done_q  <= 1'b1;
            state_q <= FINISH;
`endif
          end
        end
`ifdef FLASH_SCHED_POLL_EN
        POLL_ISSUE: begin
          if (!fi_busy) begin
            fi_start_q <= 1'b1;
            fi_instr_q <= OP_RDSR;
            fi_addr_q  <= 24'h0;
            fi_len_q   <= 16'd1;
            state_q    <= POLL_WAIT;
          end
        end
        POLL_WAIT: begin
          if (fi_done) begin
            if (!fi_status[0]) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              poll_cnt_q <= poll_next;
              if (poll_next == LIMIT) begin
                error_q <= 1'b1;
                done_q  <= 1'b1;
                state_q <= FINISH;
              end else begin
                state_q <= POLL_ISSUE;
              end
            end
          end
        end
`endif
        FINISH: begin
          done_q  <= 1'b0;
          grant_q <= 2'b00;
          last_q  <= grant_q[1];
`ifdef FLASH_SCHED_POLL_EN
          error_q    <= 1'b0;
          poll_cnt_q <= 16'h0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant          = grant_q;
  assign done           = done_q;
  assign fi_start       = fi_start_q;
  assign fi_instruction = fi_instr_q;
  assign fi_addr        = fi_addr_q;
  assign fi_len         = fi_len_q;
  assign dbg_state      = state_q;

endmodule
